// File: rtl/player_motion.sv
// player_motion: debounced direction buttons, one buffered turn request
// and bounded per-frame stepping of the player sprite position.
module player_motion #(
    parameter int START_X     = 312,
    parameter int START_Y     = 232,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 616,
    parameter int Y_MIN       = 8,
    parameter int Y_MAX       = 456,
    parameter int STEP        = 2,
    parameter int PEND_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       turn_pending
);
    typedef enum logic [1:0] {IDLE, MOVE, BLOCKED} state_t;

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_DOWN  = 2'd3;

    localparam logic [9:0]  XS     = 10'(START_X);
    localparam logic [9:0]  YS     = 10'(START_Y);
    localparam logic [9:0]  XMIN10 = 10'(X_MIN);
    localparam logic [9:0]  XMAX10 = 10'(X_MAX);
    localparam logic [9:0]  YMIN10 = 10'(Y_MIN);
    localparam logic [9:0]  YMAX10 = 10'(Y_MAX);
    localparam logic [10:0] XMIN   = 11'(X_MIN);
    localparam logic [10:0] XMAX   = 11'(X_MAX);
    localparam logic [10:0] YMIN   = 11'(Y_MIN);
    localparam logic [10:0] YMAX   = 11'(Y_MAX);
    localparam logic [10:0] STP    = 11'(STEP);
    localparam logic [3:0]  PEND   = 4'(PEND_FRAMES);

    state_t      state;
    logic [3:0]  raw, sync1, sync2, smp, stb, stb_next;
    logic [3:0]  open_dir, cnt;
    logic [1:0]  pend_dir, req_dir, mv_dir;
    logic        req, do_turn, do_cont, do_step;
    logic [10:0] x_w, y_w, x_inc, y_inc;
    logic [9:0]  x_right, x_left, y_up, y_down, nx, ny;

    // bit index equals the dir code of that button
    assign raw = {btn_down, btn_up, btn_left, btn_right};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign stb_next = (sync2 & smp) | (stb & (sync2 ^ smp));
    assign req      = |stb_next;

    always_comb begin
        req_dir = D_RIGHT;
        unique case (1'b1)
            stb_next[D_UP]:
                req_dir = D_UP;
            stb_next[D_DOWN] & ~stb_next[D_UP]:
                req_dir = D_DOWN;
            stb_next[D_LEFT] & ~stb_next[D_UP] & ~stb_next[D_DOWN]:
                req_dir = D_LEFT;
            default:
                req_dir = D_RIGHT;
        endcase
    end

    assign x_w     = {1'b0, player_x};
    assign y_w     = {1'b0, player_y};
    assign x_inc   = x_w + STP;
    assign y_inc   = y_w + STP;
    assign x_right = (x_inc > XMAX) ? XMAX10 : x_inc[9:0];
    assign y_down  = (y_inc > YMAX) ? YMAX10 : y_inc[9:0];
    assign x_left  = (x_w < XMIN + STP) ? XMIN10 : 10'(x_w - STP);
    assign y_up    = (y_w < YMIN + STP) ? YMIN10 : 10'(y_w - STP);

    assign open_dir = {y_w < YMAX, y_w > YMIN, x_w > XMIN, x_w < XMAX};

    assign do_turn = turn_pending & open_dir[pend_dir];
    assign do_cont = ~do_turn & (state == MOVE) & open_dir[dir];
    assign do_step = do_turn | do_cont;
    assign mv_dir  = do_turn ? pend_dir : dir;

    always_comb begin
        nx = player_x;
        ny = player_y;
        unique case (mv_dir)
            D_RIGHT: nx = x_right;
            D_LEFT:  nx = x_left;
            D_UP:    ny = y_up;
            D_DOWN:  ny = y_down;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_x     <= XS;
            player_y     <= YS;
            dir          <= D_RIGHT;
            moving       <= 1'b0;
            turn_pending <= 1'b0;
            pend_dir     <= D_RIGHT;
            cnt          <= '0;
            smp          <= '0;
            stb          <= '0;
            state        <= IDLE;
        end else if (soft_reset) begin
            player_x     <= XS;
            player_y     <= YS;
            dir          <= D_RIGHT;
            moving       <= 1'b0;
            turn_pending <= 1'b0;
            pend_dir     <= D_RIGHT;
            cnt          <= '0;
            smp          <= '0;
            stb          <= '0;
            state        <= IDLE;
        end else if (frame_tick) begin
            smp    <= sync2;
            stb    <= stb_next;
            moving <= do_step;
            if (do_step) begin
                player_x <= nx;
                player_y <= ny;
            end
            if (do_turn) begin
                dir   <= pend_dir;
                state <= MOVE;
            end else if (state == MOVE && !do_cont) begin
                state <= BLOCKED;
            end
            // a fresh request outranks consuming the old one
            if (req) begin
                pend_dir     <= req_dir;
                turn_pending <= 1'b1;
                cnt          <= PEND;
            end else begin
                if (do_turn)
                    turn_pending <= 1'b0;
                if (cnt != '0) begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        turn_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: vector table, directed corner sequences and random
// buttons checked against an integer reference of the player motion.
module tb_player_motion;
    logic       clk = 1'b0;
    logic       rst, soft_reset, frame_tick;
    logic [3:0] b;
    logic [9:0] x0, y0, x1, y1;
    logic [1:0] d0, d1;
    logic       mv0, mv1, tp0, tp1;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        int x, y, dir, mv, tp, pdir, cnt, st, sx;
        bit [3:0] s1, s2, smp, stb;
    } mdl_t;

    typedef struct {
        bit sr;
        bit [3:0] b;
        int x, y, d, mv, tp;
    } vec_t;

    mdl_t m0, m1;
    vec_t tv[16];

    always #5 clk = ~clk;

    player_motion u_dut (
        .clk(clk), .rst(rst), .soft_reset(soft_reset),
        .frame_tick(frame_tick),
        .btn_up(b[2]), .btn_down(b[3]),
        .btn_left(b[1]), .btn_right(b[0]),
        .player_x(x0), .player_y(y0), .dir(d0),
        .moving(mv0), .turn_pending(tp0)
    );

    player_motion #(.START_X(615)) u_edge (
        .clk(clk), .rst(rst), .soft_reset(soft_reset),
        .frame_tick(frame_tick),
        .btn_up(b[2]), .btn_down(b[3]),
        .btn_left(b[1]), .btn_right(b[0]),
        .player_x(x1), .player_y(y1), .dir(d1),
        .moving(mv1), .turn_pending(tp1)
    );

    function automatic int mclamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit mopen(mdl_t m, int d);
        case (d)
            0: return m.x < 616;
            1: return m.x > 8;
            2: return m.y > 8;
            default: return m.y < 456;
        endcase
    endfunction

    function automatic mdl_t mreset(int sx);
        mdl_t m = '{default: 0};
        m.sx = sx;
        m.x  = sx;
        m.y  = 232;
        return m;
    endfunction

    // heading vectors: right, left, up, down
    function automatic mdl_t mstep(mdl_t m, bit [3:0] raw, bit ft, bit sr);
        int dx[4] = '{1, -1, 0, 0};
        int dy[4] = '{0, 0, -1, 1};
        mdl_t n = m;
        bit [3:0] sn;
        bit req, turn, step;
        int md;
        if (sr) begin
            n.x = m.sx; n.y = 232; n.dir = 0; n.mv = 0;
            n.tp = 0; n.pdir = 0; n.cnt = 0; n.st = 0;
            n.smp = 0; n.stb = 0;
        end else if (ft) begin
            for (int k = 0; k < 4; k++)
                sn[k] = (m.s2[k] == m.smp[k]) ? m.s2[k] : m.stb[k];
            n.smp = m.s2;
            n.stb = sn;
            req  = |sn;
            turn = (m.tp != 0) && mopen(m, m.pdir);
            step = 0;
            md   = m.dir;
            if (turn) begin
                md = m.pdir; n.dir = m.pdir; n.st = 1; step = 1;
            end else if (m.st == 1 && mopen(m, m.dir)) begin
                step = 1;
            end else if (m.st == 1) begin
                n.st = 2;
            end
            if (step) begin
                n.x = mclamp(m.x + 2 * dx[md], 8, 616);
                n.y = mclamp(m.y + 2 * dy[md], 8, 456);
            end
            n.mv = (n.x != m.x || n.y != m.y) ? 1 : 0;
            if (req) begin
                n.tp = 1;
                n.cnt = 8;
                n.pdir = sn[2] ? 2 : (sn[3] ? 3 : (sn[1] ? 1 : 0));
            end else begin
                if (turn) n.tp = 0;
                if (m.cnt > 0) begin
                    n.cnt = m.cnt - 1;
                    if (n.cnt == 0) n.tp = 0;
                end
            end
        end
        n.s2 = m.s1;
        n.s1 = raw;
        return n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, mdl_t m, logic [9:0] x, logic [9:0] y,
                       logic [1:0] d, logic mv, logic tp);
        chk({tag, ".x"},   int'(x),  m.x);
        chk({tag, ".y"},   int'(y),  m.y);
        chk({tag, ".dir"}, int'(d),  m.dir);
        chk({tag, ".mv"},  int'(mv), m.mv);
        chk({tag, ".tp"},  int'(tp), m.tp);
    endtask

    task automatic cyc(bit ft, bit sr);
        frame_tick = ft;
        soft_reset = sr;
        @(posedge clk);
        if (!rst) begin
            m0 = mreset(312);
            m1 = mreset(615);
        end else begin
            m0 = mstep(m0, b, ft, sr);
            m1 = mstep(m1, b, ft, sr);
        end
        #1;
        frame_tick = 1'b0;
        soft_reset = 1'b0;
        cmp("ref", m0, x0, y0, d0, mv0, tp0);
        cmp("ref_edge", m1, x1, y1, d1, mv1, tp1);
    endtask

    task automatic frame(bit sr);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, sr);
    endtask

    initial begin
        int ex;
        tv[0]  = '{1'b0, 4'b0001, 312, 232, 0, 0, 0};
        tv[1]  = '{1'b0, 4'b0001, 312, 232, 0, 0, 1};
        tv[2]  = '{1'b0, 4'b0001, 314, 232, 0, 1, 1};
        tv[3]  = '{1'b0, 4'b0000, 316, 232, 0, 1, 1};
        tv[4]  = '{1'b0, 4'b0000, 318, 232, 0, 1, 0};
        tv[5]  = '{1'b0, 4'b0000, 320, 232, 0, 1, 0};
        tv[6]  = '{1'b1, 4'b0110, 312, 232, 0, 0, 0};
        tv[7]  = '{1'b0, 4'b0110, 312, 232, 0, 0, 0};
        tv[8]  = '{1'b0, 4'b0110, 312, 232, 0, 0, 1};
        tv[9]  = '{1'b0, 4'b0000, 312, 230, 2, 1, 1};
        tv[10] = '{1'b0, 4'b0000, 312, 228, 2, 1, 0};
        tv[11] = '{1'b0, 4'b0000, 312, 226, 2, 1, 0};
        tv[12] = '{1'b1, 4'b0000, 312, 232, 0, 0, 0};
        tv[13] = '{1'b0, 4'b0010, 312, 232, 0, 0, 0};
        tv[14] = '{1'b0, 4'b0000, 312, 232, 0, 0, 0};
        tv[15] = '{1'b0, 4'b0000, 312, 232, 0, 0, 0};

        rst = 1'b0;
        soft_reset = 1'b0;
        frame_tick = 1'b0;
        b = 4'b0000;
        m0 = mreset(312);
        m1 = mreset(615);
        repeat (3) cyc(1'b0, 1'b0);
        chk("reset.x", int'(x0), 312);
        chk("reset.y", int'(y0), 232);
        chk("reset.dir", int'(d0), 0);
        chk("reset.mv", int'(mv0), 0);
        chk("reset.tp", int'(tp0), 0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            b = tv[i].b;
            frame(tv[i].sr);
            chk($sformatf("vec%0d.x", i), int'(x0), tv[i].x);
            chk($sformatf("vec%0d.y", i), int'(y0), tv[i].y);
            chk($sformatf("vec%0d.dir", i), int'(d0), tv[i].d);
            chk($sformatf("vec%0d.mv", i), int'(mv0), tv[i].mv);
            chk($sformatf("vec%0d.tp", i), int'(tp0), tv[i].tp);
        end

        // right-edge clamp, block, then turn up on the 615 instance
        b = 4'b0000;
        frame(1'b1);
        b = 4'b0001;
        repeat (3) frame(1'b0);
        chk("clamp.x", int'(x1), 616);
        chk("clamp.mv", int'(mv1), 1);
        frame(1'b0);
        chk("block.x", int'(x1), 616);
        chk("block.mv", int'(mv1), 0);
        b = 4'b0100;
        repeat (2) frame(1'b0);
        chk("block_wait.mv", int'(mv1), 0);
        frame(1'b0);
        chk("unblock.dir", int'(d1), 2);
        chk("unblock.y", int'(y1), 230);
        chk("unblock.x", int'(x1), 616);

        // buffered up turn while running along the top edge
        b = 4'b0000;
        frame(1'b1);
        b = 4'b0100;
        repeat (120) frame(1'b0);
        chk("top.y", int'(y0), 8);
        b = 4'b0001;
        repeat (3) frame(1'b0);
        chk("top_turn.x", int'(x0), 314);
        chk("top_turn.dir", int'(d0), 0);
        b = 4'b0100;
        repeat (2) frame(1'b0);
        b = 4'b0000;
        frame(1'b0);
        ex = 320;
        chk("buf_refresh.x", int'(x0), ex);
        for (int k = 1; k <= 8; k++) begin
            frame(1'b0);
            ex += 2;
            chk($sformatf("buf%0d.tp", k), int'(tp0), (k < 8) ? 1 : 0);
            chk($sformatf("buf%0d.x", k), int'(x0), ex);
            chk($sformatf("buf%0d.y", k), int'(y0), 8);
        end

        // reach (400,100) heading down, then soft_reset on a frame tick
        frame(1'b1);
        b = 4'b0100;
        repeat (67) frame(1'b0);
        b = 4'b0001;
        repeat (44) frame(1'b0);
        b = 4'b1000;
        repeat (3) frame(1'b0);
        chk("pre_sr.x", int'(x0), 400);
        chk("pre_sr.y", int'(y0), 100);
        chk("pre_sr.dir", int'(d0), 3);
        frame(1'b1);
        chk("sr.x", int'(x0), 312);
        chk("sr.y", int'(y0), 232);
        chk("sr.dir", int'(d0), 0);
        chk("sr.mv", int'(mv0), 0);
        chk("sr.tp", int'(tp0), 0);

        // asynchronous rst in the middle of a frame
        repeat (3) frame(1'b0);
        chk("pre_rst.y", int'(y0), 234);
        chk("pre_rst.mv", int'(mv0), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst.x", int'(x0), 312);
        chk("arst.y", int'(y0), 232);
        chk("arst.dir", int'(d0), 0);
        chk("arst.mv", int'(mv0), 0);
        chk("arst.tp", int'(tp0), 0);
        chk("arst_edge.x", int'(x1), 615);
        m0 = mreset(312);
        m1 = mreset(615);
        repeat (2) cyc(1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(3) == 0)
                b = 4'($urandom);
            repeat ($urandom_range(3))
                cyc(1'b0, $urandom_range(199) == 0);
            cyc(1'b1, $urandom_range(79) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/player_motion.md
# player_motion

Player position generator feeding the dot, ghost and collision stages. Takes raw direction buttons, synchronizes and debounces them, buffers one requested turn, and advances `player_x`/`player_y` once per `frame_tick` inside fixed playfield bounds. `soft_reset` returns the player to the start tile after a collision. The downstream dot stage samples the position on `frame_tick`.

## Interface
Parameters:
- START_X, 312, x position after reset/soft_reset
- START_Y, 232, y position after reset/soft_reset
- X_MIN, 8, smallest legal player_x
- X_MAX, 616, largest legal player_x (sprite 16 px wide)
- Y_MIN, 8, smallest legal player_y
- Y_MAX, 456, largest legal player_y
- STEP, 2, pixels moved per frame (1..7)
- PEND_FRAMES, 8, frames a buffered turn survives without refresh (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- soft_reset  in  1  synchronous re-init, one-clk pulse
- frame_tick  in  1  one-clk pulse per video frame
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
- player_x  out  10  registered top-left x
- player_y  out  10  registered top-left y
- dir  out  2  current heading: 0 right, 1 left, 2 up, 3 down
- moving  out  1  1 when the last frame_tick changed position
- turn_pending  out  1  buffered turn request valid

## Operation
- Buttons pass through a 2-flop synchronizer on clk.
- Debounce, evaluated on frame_tick only:
  - `smp[k] <= sync[k]`.
  - `stb[k]` takes `sync[k]` when `sync[k] == smp[k]`; otherwise it holds.
- Request: any `stb_next` bit high. Priority up > down > left > right. On that edge:
  - pending_dir is loaded.
  - turn_pending is set to 1.
  - Expiry counter is loaded with PEND_FRAMES.
- Without a request, each frame_tick decrements the counter. When it reaches 0, turn_pending clears.
- A direction is *open* when the player is not already at the bound in that direction. For example, right is open when `player_x < X_MAX`.
- FSM states: IDLE, MOVE, BLOCKED. Reset state is IDLE. Each frame_tick uses register values from before the edge:
  - **Turn.** If turn_pending and pending_dir is open: `dir <= pending_dir`, turn_pending clears, one step in pending_dir, state goes to MOVE. Reversal is an ordinary turn.
  - **Continue.** Otherwise, in MOVE with dir open: one step in dir.
  - **Block.** Otherwise, in MOVE: no step, state goes to BLOCKED.
  - **Wait.** In IDLE or BLOCKED with no applicable turn: no step, state unchanged.
- Step arithmetic uses an 11-bit intermediate. The result is clamped to the bound, so a partial step lands exactly on the bound. Subtraction never wraps below X_MIN/Y_MIN.
- moving is 1 after a frame_tick that changed a coordinate, 0 otherwise.
- soft_reset, in priority over frame_tick:
  - player_x = START_X, player_y = START_Y, dir = 0, moving = 0.
  - turn_pending = 0, counter = 0, smp = stb = 0.
  - State goes to IDLE.
  - Synchronizer flops keep running.
- rst sets the same values asynchronously.

## Timing
- Reset values: player_x = START_X, player_y = START_Y, dir = 0, moving = 0, turn_pending = 0.
- All outputs change only on the clk edge where frame_tick or soft_reset is high. They are valid the following cycle.
- The dot stage samples on that same edge, so it sees the previous-frame position. This one-frame lag is accepted.
- Button held from before frame_tick T1 (sync settled):
  - T1: smp = 1.
  - T2: stb = 1, turn_pending = 1.
  - T3: first step. player_x changes one clk after the T3 edge.
- Pending set at T, button released at T+1: cleared after PEND_FRAMES further ticks without being applied.
- Simultaneous frame_tick and soft_reset: soft_reset wins, no step.
- rst asserted mid-frame: outputs go to reset values immediately, independent of clk.

## Test plan
- Reset: release rst, hold right 3 frame_ticks → turn_pending = 1 after tick 2. After tick 3: player_x = 314, dir = 0, moving = 1, player_y = 232.
- Clamp and block at x = 615 heading right, STEP = 2:
  - Next tick: player_x = 616, moving = 1.
  - Following tick: player_x = 616, moving = 0, state BLOCKED.
  - Press up: after the debounce ticks, dir = 2 and player_y decreases by 2.
- Buffered turn while moving right at y = 8, up pressed then released:
  - Up is not open (at Y_MIN), so it is not applied.
  - turn_pending stays 1 for exactly PEND_FRAMES = 8 ticks after the last refresh, then 0.
  - player_x keeps advancing by 2 per tick.
- Priority: up and left held together from IDLE → dir = 2, player_y = 230, player_x = 312.
- Glitch rejection: btn_left high for 1 frame only (low at next tick) → stb never set, turn_pending = 0, position unchanged.
- soft_reset coincident with frame_tick while moving at (400, 100) heading down → next cycle (312, 232), dir = 0, moving = 0, turn_pending = 0. rst pulsed mid-frame gives the same values asynchronously.
